// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions: select codes, RV32I opcodes and the
//               decode-to-ALU payload struct. Imported by the decode/issue
//               stage and by the ALU itself so both agree on encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_XLEN  = 32;
    localparam int ALU_SEL_W = 4;

    // ALU select codes; 1010-1111 are never issued
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'b0010;
    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'b0011;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'b0100;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALU_SEL_W-1:0] ALU_PASS = 4'b0110;
    localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 4'b0111;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [ALU_SEL_W-1:0] ALU_SRA  = 4'b1001;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct7 values that are legal for OP / shift-immediate encodings
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ALU_XLEN-1:0]  op1;
        logic [ALU_XLEN-1:0]  op2;
        logic [ALU_SEL_W-1:0] sel;
        logic                 sign;
        logic                 shift;
        logic [4:0]           rd;
        logic                 reg_write;
        logic                 illegal;
    } alu_payload_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Purely combinational RV32I decode into the ALU payload.
// Ports       : i_instr    - instruction word
//               i_pc       - instruction PC (AUIPC operand 1)
//               i_rs1_data - rs1 read data
//               i_rs2_data - rs2 read data
//               o_payload  - operands, select, sign/shift flags, rd, we, illegal
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0]  i_instr,
    input  logic [31:0]  i_pc,
    input  logic [31:0]  i_rs1_data,
    input  logic [31:0]  i_rs2_data,
    output alu_payload_t o_payload
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic        w_f7_base;
    logic        w_f7_alt;
    logic        w_is_op;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic [31:0] w_shamt;

    assign w_opcode  = i_instr[6:0];
    assign w_rd      = i_instr[11:7];
    assign w_f3      = i_instr[14:12];
    assign w_f7      = i_instr[31:25];
    assign w_f7_base = (w_f7 == F7_BASE);
    assign w_f7_alt  = (w_f7 == F7_ALT);
    assign w_is_op   = (w_opcode == OPC_OP);
    assign w_imm_i   = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_u   = {i_instr[31:12], 12'h000};
    assign w_shamt   = {27'b0, i_instr[24:20]};

    alu_payload_t w_pay;
    logic [3:0]   w_sel;
    logic         w_sign;
    logic         w_wr;
    logic         w_ill;

    always_comb begin
        // Unknown opcodes still carry the raw register operands so a trap
        // handler downstream can inspect them.
        w_pay     = '0;
        w_pay.op1 = i_rs1_data;
        w_pay.op2 = i_rs2_data;
        w_sel     = ALU_ADD;
        w_sign    = 1'b0;
        w_wr      = 1'b0;
        w_ill     = 1'b0;

        case (w_opcode)
            OPC_OP, OPC_OPIMM: begin
                w_wr = 1'b1;
                if (!w_is_op) begin
                    w_pay.op2 = (w_f3 == 3'b001 || w_f3 == 3'b101) ? w_shamt : w_imm_i;
                end
                case (w_f3)
                    3'b000:  w_sel = (w_is_op && w_f7_alt) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_sel = ALU_SLL;
                    3'b010:  begin w_sel = ALU_SLT; w_sign = 1'b1; end
                    3'b011:  w_sel = ALU_SLT;
                    3'b100:  w_sel = ALU_XOR;
                    3'b101:  begin
                        w_sel  = w_f7_alt ? ALU_SRA : ALU_SRL;
                        w_sign = w_f7_alt;
                    end
                    3'b110:  w_sel = ALU_OR;
                    default: w_sel = ALU_AND;
                endcase
                // The alternate funct7 only means something for SUB/SRA(I);
                // immediate non-shift forms use those bits as immediate.
                if (w_is_op) begin
                    w_ill = !(w_f7_base || (w_f7_alt && (w_f3 == 3'b000 || w_f3 == 3'b101)));
                end else if (w_f3 == 3'b001) begin
                    w_ill = !w_f7_base;
                end else if (w_f3 == 3'b101) begin
                    w_ill = !(w_f7_base || w_f7_alt);
                end
            end
            OPC_LUI: begin
                w_pay.op1 = '0;
                w_pay.op2 = w_imm_u;
                w_sel     = ALU_PASS;
                w_wr      = 1'b1;
            end
            OPC_AUIPC: begin
                w_pay.op1 = i_pc;
                w_pay.op2 = w_imm_u;
                w_wr      = 1'b1;
            end
            OPC_LOAD: begin
                w_pay.op2 = w_imm_i;
                w_wr      = 1'b1;
            end
            OPC_STORE: begin
                w_pay.op2 = w_imm_s;
            end
            OPC_BRANCH: begin
                case (w_f3)
                    3'b000, 3'b001: w_sel = ALU_SUB;
                    3'b100, 3'b101: begin w_sel = ALU_SLT; w_sign = 1'b1; end
                    3'b110, 3'b111: w_sel = ALU_SLT;
                    default:        w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase

        if (w_ill) begin
            w_sel  = ALU_ADD;
            w_sign = 1'b0;
            w_wr   = 1'b0;
        end

        w_pay.sel       = w_sel;
        w_pay.sign      = w_sign;
        w_pay.shift     = (w_sel == ALU_SLL) || (w_sel == ALU_SRL) || (w_sel == ALU_SRA);
        w_pay.rd        = w_rd;
        w_pay.reg_write = w_wr && (w_rd != 5'd0);
        w_pay.illegal   = w_ill;
    end

    assign o_payload = w_pay;

endmodule : alu_ctrl_decode
`default_nettype wire

// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_stage
// Description : Decode/issue register in front of the ALU. One registered
//               entry with valid/ready on both sides and a flush input.
//               Build option ALU_CTRL_SKID_EN adds a second (skid) entry and
//               makes o_ready a register equal to "skid empty".
// Ports       : i_clk/i_rst_n          - clock, async active-low reset
//               i_valid/o_ready        - upstream handshake
//               i_instr/i_pc/i_rs*_data- instruction and register read data
//               i_flush                - kill held and incoming instruction
//               o_valid/i_ready        - ALU-side handshake
//               o_op1/o_op2/o_alu_sel/o_sign/o_shift/o_rd/o_reg_write/
//               o_illegal              - ALU payload
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_op1,
    output logic [XLEN-1:0]  o_op2,
    output logic [SEL_W-1:0] o_alu_sel,
    output logic             o_sign,
    output logic             o_shift,
    output logic [4:0]       o_rd,
    output logic             o_reg_write,
    output logic             o_illegal
);

    alu_payload_t w_dec;

    alu_ctrl_decode u_decode (
        .i_instr    (i_instr),
        .i_pc       (i_pc),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .o_payload  (w_dec)
    );

    logic         valid_q, valid_d;
    alu_payload_t pay_q,   pay_d;
    logic         w_accept;

`ifdef ALU_CTRL_SKID_EN
    logic         skid_valid_q, skid_valid_d;
    alu_payload_t skid_q,       skid_d;

    assign o_ready  = !skid_valid_q;
    assign w_accept = i_valid && !skid_valid_q;

    always_comb begin
        valid_d      = valid_q;
        pay_d        = pay_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (i_flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid occupied implies output occupied and no new accept;
            // the older skid entry moves up as soon as EX takes the head.
            if (i_ready) begin
                pay_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (!valid_q || i_ready) begin
            valid_d = w_accept;
            if (w_accept) begin
                pay_d = w_dec;
            end
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_d       = w_dec;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            pay_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            valid_q      <= valid_d;
            pay_q        <= pay_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
`else
    assign o_ready  = !valid_q || i_ready;
    assign w_accept = i_valid && o_ready;

    // Flush wins over both load and hold; payload only moves on accept so
    // stale contents behind o_valid=0 are harmless.
    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            valid_d = 1'b1;
            pay_d   = w_dec;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end
`endif

    assign o_valid     = valid_q;
    assign o_op1       = pay_q.op1;
    assign o_op2       = pay_q.op2;
    assign o_alu_sel   = pay_q.sel;
    assign o_sign      = pay_q.sign;
    assign o_shift     = pay_q.shift;
    assign o_rd        = pay_q.rd;
    assign o_reg_write = pay_q.reg_write;
    assign o_illegal   = pay_q.illegal;

endmodule : alu_ctrl_stage
`default_nettype wire

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Decode/issue register that sits immediately upstream of the ALU.
- Turns an RV32I instruction and its register-file read data into the ALU's operand/control interface: operand 1, operand 2, 4-bit select, sign, shift. Also carries rd and write-enable.
- One-entry registered pipeline stage with valid/ready handshakes on both sides and a flush input.

Parameters:
- XLEN, 32, datapath width (fixed at 32; a parameter only for readability).
- SEL_W, 4, ALU select width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept
- i_instr  in  32  instruction word
- i_pc  in  32  instruction PC
- i_rs1_data  in  32  rs1 read data
- i_rs2_data  in  32  rs2 read data
- i_flush  in  1  kill held and incoming instruction
- o_valid  out  1  ALU-side payload valid
- i_ready  in  1  EX stage accepts payload
- o_op1  out  32  ALU operand 1
- o_op2  out  32  ALU operand 2
- o_alu_sel  out  4  ALU select
- o_sign  out  1  signed compare/shift
- o_shift  out  1  op is a shift
- o_rd  out  5  destination register
- o_reg_write  out  1  writes rd
- o_illegal  out  1  unsupported encoding

Behaviour:
- Reset is asynchronous, active-low. While reset is asserted:
  - o_valid, o_op1, o_op2, o_alu_sel, o_sign, o_shift, o_rd, o_reg_write and o_illegal are all 0.
  - o_ready is 1 after reset.
- ALU select encoding:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 ADD, 0100 SUB, 0101 SLT, 0110 PASS op2.
  - 0111 SLL, 1000 SRL, 1001 SRA. 1010–1111 are never issued.
- Sign and shift outputs:
  - o_sign=1 for SLT/SLTI, the SLT used by BLT/BGE, and SRA/SRAI; 0 otherwise.
  - o_shift=1 for select 0111/1000/1001.
- Decode by opcode:
  - OP (0110011): op1=rs1, op2=rs2. Select from funct3/funct7. SLTU uses SLT with sign=0. SUB and SRA need funct7=0100000; any other funct7 other than 0000000 is illegal.
  - OP-IMM (0010011): op1=rs1, op2=sign-extended I-immediate. For shifts, op2={27'b0, shamt}. SLLI/SRLI need funct7=0000000 and SRAI needs 0100000, else illegal.
  - LUI: op1=0, op2=U-immediate, select PASS.
  - AUIPC: op1=pc, op2=U-immediate, select ADD.
  - LOAD: ADD, op1=rs1, op2=I-immediate, reg_write=1.
  - STORE: ADD, op1=rs1, op2=S-immediate, reg_write=0.
  - BRANCH: op1=rs1, op2=rs2, reg_write=0. BEQ/BNE use SUB. BLT/BGE use SLT with sign=1. BLTU/BGEU use SLT with sign=0. funct3 010/011 is illegal.
  - Any other opcode is illegal.
- Illegal handling: o_illegal=1, select ADD, reg_write=0; the payload is still passed so EX can trap.
- reg_write=0 whenever rd=0.
- Handshake:
  - Accept when i_valid && o_ready. Latency is 1 cycle: the payload is registered on the accepting edge.
  - o_ready = !o_valid || i_ready (combinational). Back-to-back throughput is 1 per cycle.
  - When o_valid && !i_ready, the payload is held stable and o_valid stays 1.
- Flush:
  - i_flush for one cycle clears o_valid on the next edge and discards any same-cycle input.
  - Flush has priority over load and over hold.
- Flush and accept in the same cycle: the input is dropped and o_valid=0 next cycle.
- Reset mid-hold: the payload is lost and outputs are forced to their reset values immediately.
- Payload registers update only on accept, so stale data is harmless when o_valid=0.

Optional Feature:
- Macro: ALU_CTRL_SKID_EN.
- Defined: a second skid entry is added, and o_ready is registered, equal to "skid empty".
  - An instruction accepted while downstream stalls lands in the skid entry.
  - When i_ready returns, the skid entry drains to the output first, so order is preserved.
  - Flush clears both entries.
- Undefined: single entry with combinational o_ready, as described in Behaviour.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_AND..ALU_SRA select constants.
  - Opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_BRANCH.
  - A typedef for the ALU payload struct.
- The ALU itself consumes the same constants.
- One combinational sub-module, alu_ctrl_decode, maps instr/pc/rs data to the payload. The top module owns the registers, handshake and skid.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, i_ready=1 -> next cycle o_valid=1, sel=0011, op1=5, op2=7, rd=3, reg_write=1, sign=0, shift=0.
- SRAI x1,x2,4 (0x40415093), rs1=0x80000000 -> sel=1001, op2=4, sign=1, shift=1, illegal=0.
- LUI x5,0x12345 (0x123452B7) -> sel=0110, op1=0, op2=0x12345000, reg_write=1. Then 0xFFFFFFFF -> o_illegal=1, reg_write=0, sel=0011.
- Hold i_ready=0 for 3 cycles after an accept -> payload stable, o_ready=0 (no skid). With ALU_CTRL_SKID_EN: one more instruction is accepted, then both are issued in order once i_ready=1.
- Assert i_flush with i_valid=1 and a held payload -> next cycle o_valid=0, the input is not issued, and o_ready=1.
- Assert i_rst_n=0 asynchronously while o_valid=1 -> o_valid and all outputs 0 without waiting for a clock edge. Issue BLTU (funct3 110) after release -> sel=0101, sign=0, reg_write=0.
